// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory address/data plus the
// valid/ready handshake toward the decoder.
interface imem_fetch_ctrl_if #(
    parameter int V = 32
);
    logic [V-1:0] imem_addr;
    logic [V-1:0] imem_rdata;
    logic         if_valid;
    logic         if_ready;
    logic [V-1:0] if_instr;
    logic [V-1:0] if_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output if_valid,
        output if_instr,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output if_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller with a small prefetch FIFO.
// Define FETCH_PERF_EN to add fetch/stall performance counters.
module imem_fetch_ctrl #(
    parameter int             V         = 32,
    parameter int             ram_size  = 512,
    parameter int             DEPTH     = 2,
    parameter logic [V-1:0]   BOOT_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt_req,
    input  logic          redirect_valid,
    input  logic [V-1:0]  redirect_pc,
    imem_fetch_ctrl_if.master fbus,
    output logic          busy,
    output logic          fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]  FULL      = (AW+1)'(DEPTH);
    localparam logic [V-1:0] RAM_WORDS = V'(ram_size);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [V-1:0]  pc_q, pc_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic          err_q, err_d;
    logic [V-1:0]  ins_q [DEPTH];
    logic [V-1:0]  pcb_q [DEPTH];

    logic pop_ok, pop, push, flush;
    logic has_slot, in_range;

    assign fbus.imem_addr = pc_q;
    assign fbus.if_valid  = (count_q != '0);
    assign fbus.if_instr  = fbus.if_valid ? ins_q[rd_q] : '0;
    assign fbus.if_pc     = fbus.if_valid ? pcb_q[rd_q] : '0;
    assign busy           = (state_q != S_IDLE);
    assign fetch_err      = err_q;

    assign pop_ok   = fbus.if_valid && fbus.if_ready;
    assign has_slot = (count_q < FULL) || pop_ok;
    assign in_range = {2'b00, pc_q[V-1:2]} < RAM_WORDS;

    // Priority: redirect > halt > out-of-range > normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = BOOT_ADDR;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = {redirect_pc[V-1:2], 2'b00};
                    if (redirect_pc[1:0] != 2'b00)
                        err_d = 1'b1;
                end else if (halt_req) begin
                    pop     = pop_ok;
                    state_d = S_DRAIN;
                end else begin
                    pop = pop_ok;
                    if (has_slot) begin
                        if (in_range) begin
                            push = 1'b1;
                            pc_d = pc_q + V'(4);
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pop = pop_ok;
                    if (count_q == '0 ||
                        (count_q == (AW+1)'(1) && pop_ok))
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (flush) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
            rd_d    = rd_q + AW'(pop);
            wr_d    = wr_q + AW'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= BOOT_ADDR;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ins_q[i] <= '0;
                pcb_q[i] <= '0;
            end
        end else if (push) begin
            ins_q[wr_q] <= fbus.imem_rdata;
            pcb_q[wr_q] <= pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] pf_q, pf_d;
    logic [31:0] ps_q, ps_d;
    logic        stall;

    assign stall = fbus.if_valid && !fbus.if_ready;

    always_comb begin
        pf_d = pf_q;
        ps_d = ps_q;
        if (push && pf_q != '1)
            pf_d = pf_q + 32'd1;
        if (stall && ps_q != '1)
            ps_d = ps_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_q <= '0;
            ps_q <= '0;
        end else begin
            pf_q <= pf_d;
            ps_q <= ps_d;
        end
    end

    assign perf_fetch_cnt = pf_q;
    assign perf_stall_cnt = ps_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl against a queue-based
// reference model, with directed scenarios pinning literal values.
module tb_imem_fetch_ctrl;
    localparam int V     = 32;
    localparam int RAM   = 512;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [V-1:0]  redirect_pc = '0;
    logic          busy;
    logic          fetch_err;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    imem_fetch_ctrl_if #(.V(V)) fb();

    imem_fetch_ctrl #(
        .V(V), .ram_size(RAM), .DEPTH(DEPTH), .BOOT_ADDR('0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .halt_req(halt_req),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fbus(fb),
        .busy(busy),
        .fetch_err(fetch_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [RAM];
    assign fb.imem_rdata = (fb.imem_addr[31:2] < 30'(RAM)) ?
                           mem[fb.imem_addr[10:2]] : 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          mode;
    logic [31:0] m_pc;
    bit          m_err;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode    = 0;
        m_pc    = 0;
        m_err   = 0;
        m_fetch = 0;
        m_stall = 0;
    endtask

    // Advance the model across one rising edge using current inputs.
    task automatic model_step();
        bit pop;
        bit free;
        pop = (q.size() > 0) && fb.if_ready;
        if (q.size() > 0 && !fb.if_ready) m_stall++;
        case (mode)
            0: if (start) begin
                mode = 1;
                m_pc = 0;
            end
            1: begin
                if (redirect_valid) begin
                    q.delete();
                    if (redirect_pc[1:0] != 2'b00) m_err = 1;
                    m_pc = redirect_pc & ~32'd3;
                end else if (halt_req) begin
                    if (pop) void'(q.pop_front());
                    mode = 2;
                end else begin
                    free = (q.size() < DEPTH) || pop;
                    if (pop) void'(q.pop_front());
                    if (free) begin
                        if (m_pc / 4 >= RAM) begin
                            m_err = 1;
                            mode  = 2;
                        end else begin
                            q.push_back({mem[m_pc / 4], m_pc});
                            m_pc = m_pc + 4;
                            m_fetch++;
                        end
                    end
                end
            end
            default: begin
                if (redirect_valid) begin
                    q.delete();
                    mode = 0;
                end else begin
                    if (pop) void'(q.pop_front());
                    if (q.size() == 0) mode = 0;
                end
            end
        endcase
    endtask

    task automatic compare();
        bit v;
        v = q.size() > 0;
        chk("if_valid", fb.if_valid, v);
        chk("if_pc", fb.if_pc, v ? q[0].pc : 32'd0);
        chk("if_instr", fb.if_instr, v ? q[0].instr : 32'd0);
        chk("busy", busy, mode != 0);
        chk("fetch_err", fetch_err, m_err);
        chk("imem_addr", fb.imem_addr, m_pc);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    endtask

    task automatic cycle(input bit st, input bit hl, input bit rv,
                         input logic [31:0] rp, input bit rdy);
        start          = st;
        halt_req       = hl;
        redirect_valid = rv;
        redirect_pc    = rp;
        fb.if_ready    = rdy;
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset asserted between edges, released a cycle later.
    task automatic pulse_reset();
        start = 0; halt_req = 0; redirect_valid = 0; fb.if_ready = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        chk("rst_busy", busy, 0);
        chk("rst_valid", fb.if_valid, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_pc", fb.imem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] last_pc;
        int n;
        for (int i = 0; i < RAM; i++) mem[i] = $urandom;
        fb.if_ready = 1'b0;
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Streaming from boot with the decoder always ready.
        cycle(1, 0, 0, 0, 1);
        chk("s_valid0", fb.if_valid, 0);
        chk("s_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 1);
            chk("s_pc", fb.if_pc, 32'(4 * i));
            chk("s_instr", fb.if_instr, mem[i]);
        end

        // Backpressure from start: head held, stream resumes gap-free.
        pulse_reset();
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        chk("bp_hold", fb.if_pc, 0);
        chk("bp_fetched", fb.imem_addr, 32'(4 * DEPTH));
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 0, 0, 0, 1);
            chk("bp_pc", fb.if_pc, 32'(4 * i));
        end

        // Redirect with a full buffer, then a misaligned redirect.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h40, 0);
        chk("rd_flush", fb.if_valid, 0);
        cycle(0, 0, 0, 0, 1);
        chk("rd_pc0", fb.if_pc, 32'h40);
        cycle(0, 0, 0, 0, 1);
        chk("rd_pc1", fb.if_pc, 32'h44);
        cycle(0, 0, 1, 32'h42, 1);
        chk("mis_err", fetch_err, 1);
        cycle(0, 0, 0, 0, 1);
        chk("mis_pc", fb.if_pc, 32'h40);

        // Redirect outranks halt in the same cycle.
        cycle(0, 1, 1, 32'h100, 1);
        cycle(0, 0, 0, 0, 1);
        chk("pri_valid", fb.if_valid, 1);
        chk("pri_pc", fb.if_pc, 32'h100);
        cycle(0, 1, 0, 0, 1);
        n = 0;
        while (busy && n < 10) begin
            cycle(0, 0, 0, 0, 1);
            n++;
        end
        chk("halt_idle", busy, 0);

        // Reset pulsed in the middle of a stream.
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        pulse_reset();

        // Run off the end of memory.
        cycle(1, 0, 0, 0, 1);
        last_pc = 0;
        n = 0;
        while (!fetch_err && n < 700) begin
            if (fb.if_valid) last_pc = fb.if_pc;
            cycle(0, 0, 0, 0, 1);
            n++;
        end
        chk("oor_err", fetch_err, 1);
        n = 0;
        while (busy && n < 10) begin
            if (fb.if_valid) last_pc = fb.if_pc;
            cycle(0, 0, 0, 0, 1);
            n++;
        end
        chk("oor_idle", busy, 0);
        chk("oor_last", last_pc, 32'h7FC);

        // Random mix of all controls.
        pulse_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rp;
            rp = $urandom % 32'h900;
            if ($urandom % 4 != 0) rp = rp & ~32'd3;
            if ($urandom % 400 == 0) begin
                pulse_reset();
            end else begin
                cycle(($urandom % 8) == 0, ($urandom % 25) == 0,
                      ($urandom % 12) == 0, rp, ($urandom % 10) < 7);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
